// File: rtl/lab3_mem_blocking_cache_assoc_ctrl.sv
// Control unit for a blocking write-back, write-allocate cache with 1- or 2-way sets.
// Owns valid/dirty/LRU state and sequences tag check, eviction, refill and response.
module lab3_mem_blocking_cache_assoc_ctrl #(
    parameter int p_num_sets = 16,
    parameter int p_num_ways = 1,
    localparam int c_idw = $clog2(p_num_sets),
    localparam int c_wyw = (p_num_ways > 1) ? $clog2(p_num_ways) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cachereq_val,
    output logic                  o_cachereq_rdy,
    output logic                  o_cacheresp_val,
    input  logic                  i_cacheresp_rdy,
    output logic                  o_memreq_val,
    input  logic                  i_memreq_rdy,
    input  logic                  i_memresp_val,
    output logic                  o_memresp_rdy,
    input  logic [2:0]            i_cachereq_type,
    input  logic [c_idw-1:0]      i_cachereq_idx,
    input  logic [p_num_ways-1:0] i_tag_match,
    output logic                  o_cachereq_en,
    output logic                  o_memresp_en,
    output logic                  o_write_data_mux_sel,
    output logic                  o_tag_array_ren,
    output logic [p_num_ways-1:0] o_tag_array_wen,
    output logic                  o_data_array_ren,
    output logic [p_num_ways-1:0] o_data_array_wen,
    output logic                  o_data_array_wben_full,
    output logic [c_wyw-1:0]      o_way_sel,
    output logic                  o_read_data_reg_en,
    output logic                  o_evict_addr_reg_en,
    output logic                  o_memreq_addr_mux_sel,
    output logic [2:0]            o_memreq_type,
    output logic [2:0]            o_cacheresp_type,
    output logic                  o_cacheresp_hit
);

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_TC   = 4'd1;
    localparam logic [3:0] ST_IN   = 4'd2;
    localparam logic [3:0] ST_RD   = 4'd3;
    localparam logic [3:0] ST_WD   = 4'd4;
    localparam logic [3:0] ST_EP   = 4'd5;
    localparam logic [3:0] ST_ER   = 4'd6;
    localparam logic [3:0] ST_EW   = 4'd7;
    localparam logic [3:0] ST_RR   = 4'd8;
    localparam logic [3:0] ST_RW   = 4'd9;
    localparam logic [3:0] ST_RU   = 4'd10;
    localparam logic [3:0] ST_WAIT = 4'd11;
    localparam logic [3:0] ST_RST  = 4'd15;

    logic [3:0]            r_state;
    logic [3:0]            w_next_state;
    logic [c_wyw-1:0]      r_way;
    logic                  r_hit;
    logic [p_num_ways-1:0] r_valid [p_num_sets];
    logic [p_num_ways-1:0] r_dirty [p_num_sets];
    logic [p_num_sets-1:0] r_lru;

    logic [p_num_ways-1:0] w_hit_vec;
    logic                  w_hit;
    logic [c_wyw-1:0]      w_hit_way;
    logic [c_wyw-1:0]      w_inv_way;
    logic                  w_all_valid;
    logic [c_wyw-1:0]      w_lru_way;
    logic [c_wyw-1:0]      w_victim;
    logic [c_wyw-1:0]      w_tc_way;
    logic                  w_victim_dirty;
    logic [p_num_ways-1:0] w_way_onehot;
    logic                  w_is_init;
    logic                  w_is_write;

    assign w_is_init  = (i_cachereq_type == 3'd2);
    assign w_is_write = (i_cachereq_type == 3'd1);

    // Tag-check results: hit way, victim choice (lowest invalid, else LRU) and victim dirtiness
    always_comb begin
        w_hit_vec      = r_valid[i_cachereq_idx] & i_tag_match;
        w_hit          = |w_hit_vec;
        w_all_valid    = &r_valid[i_cachereq_idx];
        w_lru_way      = (p_num_ways == 2) ? c_wyw'(r_lru[i_cachereq_idx]) : '0;
        w_hit_way      = '0;
        w_inv_way      = '0;
        for (int w = p_num_ways - 1; w >= 0; w--) begin
            w_hit_way = w_hit_vec[w] ? c_wyw'(w) : w_hit_way;
            w_inv_way = r_valid[i_cachereq_idx][w] ? w_inv_way : c_wyw'(w);
        end
        w_victim       = w_all_valid ? w_lru_way : w_inv_way;
        w_tc_way       = w_hit ? w_hit_way : w_victim;
        w_victim_dirty = 1'b0;
        w_way_onehot   = '0;
        for (int w = 0; w < p_num_ways; w++) begin
            w_victim_dirty  = (w_victim == c_wyw'(w))
                            ? (r_valid[i_cachereq_idx][w] & r_dirty[i_cachereq_idx][w])
                            : w_victim_dirty;
            w_way_onehot[w] = (r_way == c_wyw'(w));
        end
    end

    // Next-state selection
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: w_next_state = i_cachereq_val ? ST_TC : ST_IDLE;
            ST_TC: begin
                if (w_is_init) begin
                    w_next_state = ST_IN;
                end else if (w_hit) begin
                    w_next_state = w_is_write ? ST_WD : ST_RD;
                end else begin
                    w_next_state = w_victim_dirty ? ST_EP : ST_RR;
                end
            end
            ST_IN:   w_next_state = ST_WAIT;
            ST_RD:   w_next_state = ST_WAIT;
            ST_WD:   w_next_state = ST_WAIT;
            ST_EP:   w_next_state = ST_ER;
            ST_ER:   w_next_state = i_memreq_rdy ? ST_EW : ST_ER;
            ST_EW:   w_next_state = i_memresp_val ? ST_RR : ST_EW;
            ST_RR:   w_next_state = i_memreq_rdy ? ST_RW : ST_RR;
            ST_RW:   w_next_state = i_memresp_val ? ST_RU : ST_RW;
            ST_RU:   w_next_state = w_is_write ? ST_WD : ST_RD;
            ST_WAIT: w_next_state = i_cacheresp_rdy ? ST_IDLE : ST_WAIT;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath controls; reset steers to an encoding that leaves every control at 0
    always_comb begin
        o_cachereq_rdy         = 1'b0;
        o_cachereq_en          = 1'b0;
        o_cacheresp_val        = 1'b0;
        o_memreq_val           = 1'b0;
        o_memresp_rdy          = 1'b0;
        o_memresp_en           = 1'b0;
        o_write_data_mux_sel   = 1'b0;
        o_tag_array_ren        = 1'b0;
        o_tag_array_wen        = '0;
        o_data_array_ren       = 1'b0;
        o_data_array_wen       = '0;
        o_data_array_wben_full = 1'b0;
        o_read_data_reg_en     = 1'b0;
        o_evict_addr_reg_en    = 1'b0;
        o_memreq_addr_mux_sel  = 1'b0;
        o_memreq_type          = 3'd0;
        case (i_reset ? ST_RST : r_state)
            ST_IDLE: begin
                o_cachereq_rdy = 1'b1;
                o_cachereq_en  = 1'b1;
            end
            ST_TC: o_tag_array_ren = 1'b1;
            ST_IN: begin
                o_tag_array_wen        = w_way_onehot;
                o_data_array_wen       = w_way_onehot;
                o_data_array_wben_full = 1'b1;
            end
            ST_RD: begin
                o_data_array_ren   = 1'b1;
                o_read_data_reg_en = 1'b1;
            end
            ST_WD: o_data_array_wen = w_way_onehot;
            ST_EP: begin
                o_data_array_ren    = 1'b1;
                o_evict_addr_reg_en = 1'b1;
                o_read_data_reg_en  = 1'b1;
            end
            ST_ER: begin
                o_memreq_val  = 1'b1;
                o_memreq_type = 3'd1;
            end
            ST_EW, ST_RW: begin
                o_memresp_rdy = 1'b1;
                o_memresp_en  = 1'b1;
            end
            ST_RR: begin
                o_memreq_val          = 1'b1;
                o_memreq_addr_mux_sel = 1'b1;
            end
            ST_RU: begin
                o_tag_array_wen        = w_way_onehot;
                o_data_array_wen       = w_way_onehot;
                o_data_array_wben_full = 1'b1;
                o_write_data_mux_sel   = 1'b1;
            end
            ST_WAIT: o_cacheresp_val = 1'b1;
            default: o_cachereq_rdy = 1'b0;
        endcase
    end

    assign o_way_sel        = r_way;
    assign o_cacheresp_type = i_cachereq_type;
    assign o_cacheresp_hit  = r_hit;

    // State, captured way/hit and per-set valid/dirty/LRU bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_way   <= '0;
            r_hit   <= 1'b0;
            r_lru   <= '0;
            for (int s = 0; s < p_num_sets; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_TC) begin
                r_way <= w_tc_way;
                r_hit <= w_hit & ~w_is_init;
            end
            for (int w = 0; w < p_num_ways; w++) begin
                if (w_way_onehot[w] && (r_state == ST_IN || r_state == ST_RU)) begin
                    r_valid[i_cachereq_idx][w] <= 1'b1;
                    r_dirty[i_cachereq_idx][w] <= 1'b0;
                end
                if (w_way_onehot[w] && r_state == ST_WD) begin
                    r_dirty[i_cachereq_idx][w] <= 1'b1;
                end
            end
            // The way just touched becomes MRU, so the other one is next to go
            if (p_num_ways == 2 && (r_state == ST_IN || r_state == ST_RD || r_state == ST_WD)) begin
                r_lru[i_cachereq_idx] <= ~r_way[0];
            end
        end
    end

endmodule

// File: tb/tb_lab3_mem_blocking_cache_assoc_ctrl.sv
// Randomized self-checking bench: a 2-way, 16-set cache state model predicts hit,
// way, write-back need and response latency for each request.
module tb_lab3_mem_blocking_cache_assoc_ctrl;

    localparam int NS  = 16;
    localparam int NW  = 2;
    localparam int IDW = 4;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_cachereq_val, i_cacheresp_rdy, i_memreq_rdy, i_memresp_val;
    logic [2:0]    i_cachereq_type;
    logic [IDW-1:0] i_cachereq_idx;
    logic [NW-1:0] i_tag_match;
    logic          o_cachereq_rdy, o_cacheresp_val, o_memreq_val, o_memresp_rdy;
    logic          o_cachereq_en, o_memresp_en, o_write_data_mux_sel, o_tag_array_ren;
    logic [NW-1:0] o_tag_array_wen, o_data_array_wen;
    logic          o_data_array_ren, o_data_array_wben_full;
    logic [0:0]    o_way_sel;
    logic          o_read_data_reg_en, o_evict_addr_reg_en, o_memreq_addr_mux_sel;
    logic [2:0]    o_memreq_type, o_cacheresp_type;
    logic          o_cacheresp_hit;

    always #5 clk = ~clk;

    lab3_mem_blocking_cache_assoc_ctrl #(.p_num_sets(NS), .p_num_ways(NW)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_cachereq_val(i_cachereq_val), .o_cachereq_rdy(o_cachereq_rdy),
        .o_cacheresp_val(o_cacheresp_val), .i_cacheresp_rdy(i_cacheresp_rdy),
        .o_memreq_val(o_memreq_val), .i_memreq_rdy(i_memreq_rdy),
        .i_memresp_val(i_memresp_val), .o_memresp_rdy(o_memresp_rdy),
        .i_cachereq_type(i_cachereq_type), .i_cachereq_idx(i_cachereq_idx),
        .i_tag_match(i_tag_match), .o_cachereq_en(o_cachereq_en),
        .o_memresp_en(o_memresp_en), .o_write_data_mux_sel(o_write_data_mux_sel),
        .o_tag_array_ren(o_tag_array_ren), .o_tag_array_wen(o_tag_array_wen),
        .o_data_array_ren(o_data_array_ren), .o_data_array_wen(o_data_array_wen),
        .o_data_array_wben_full(o_data_array_wben_full), .o_way_sel(o_way_sel),
        .o_read_data_reg_en(o_read_data_reg_en), .o_evict_addr_reg_en(o_evict_addr_reg_en),
        .o_memreq_addr_mux_sel(o_memreq_addr_mux_sel), .o_memreq_type(o_memreq_type),
        .o_cacheresp_type(o_cacheresp_type), .o_cacheresp_hit(o_cacheresp_hit)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference cache state, plus the tag array the datapath would hold
    bit m_valid [NS][NW];
    bit m_dirty [NS][NW];
    int m_tag   [NS][NW];
    bit m_lru   [NS];
    int dp_tag  [NS][NW];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_lru[s] = 1'b0;
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] ctl_outs();
        return 32'({o_cachereq_rdy, o_cacheresp_val, o_memreq_val, o_memresp_rdy,
                    o_cachereq_en, o_memresp_en, o_tag_array_ren, o_data_array_ren,
                    o_read_data_reg_en, o_evict_addr_reg_en, o_tag_array_wen, o_data_array_wen});
    endfunction

    // Memory answers two cycles after a request is accepted; each memreq may be held off
    // for mstall cycles and the response for rstall cycles.
    task automatic run_req(input logic [2:0] typ, input int idx, input int tg,
                           input int mstall, input int rstall, input bit abort_rw);
        bit hit, wb, done, seen_resp, rdy_bad, aborted, hold_hit;
        int way, exp_lat, resp_at, mst, rst_cnt;
        logic [31:0] exp_seq, exp_twen, exp_dwen, seq;
        logic [NW-1:0] twen, dwen, cur_twen;

        hit = 1'b0;
        way = 0;
        for (int w = NW - 1; w >= 0; w--) begin
            if (m_valid[idx][w] && m_tag[idx][w] == tg) begin
                hit = 1'b1;
                way = w;
            end
        end
        if (!hit) begin
            way = int'(m_lru[idx]);
            for (int w = NW - 1; w >= 0; w--) if (!m_valid[idx][w]) way = w;
        end
        wb = !hit && typ != 3'd2 && m_valid[idx][way] && m_dirty[idx][way];
        if (typ == 3'd2 || hit) begin
            exp_lat = 3;
            exp_seq = 32'h0;
        end else if (wb) begin
            exp_lat = 11 + 2 * mstall;
            exp_seq = 32'h8190;
        end else begin
            exp_lat = 7 + mstall;
            exp_seq = 32'h90;
        end
        exp_twen = (typ == 3'd2 || !hit) ? (32'd1 << way) : 32'd0;
        exp_dwen = (typ == 3'd2 || !hit || typ == 3'd1) ? (32'd1 << way) : 32'd0;

        @(negedge clk);
        i_cachereq_val  = 1'b1;
        i_cachereq_type = typ;
        i_cachereq_idx  = IDW'(idx);
        i_cacheresp_rdy = 1'b0;
        i_memreq_rdy    = 1'b0;
        i_memresp_val   = 1'b0;
        i_tag_match     = '0;
        #1;
        chk_eq("req_rdy", 32'(o_cachereq_rdy), 32'd1);
        chk_eq("req_en", 32'(o_cachereq_en), 32'd1);
        @(posedge clk);

        resp_at = -1; mst = 0; rst_cnt = 0; seq = 32'h0;
        twen = '0; dwen = '0; done = 1'b0; seen_resp = 1'b0;
        rdy_bad = 1'b0; aborted = 1'b0; hold_hit = 1'b0;
        for (int c = 1; c <= 80 && !done && !aborted; c++) begin
            @(negedge clk);
            i_cachereq_val = 1'b0;
            for (int w = 0; w < NW; w++) i_tag_match[w] = (dp_tag[idx][w] == tg);
            i_memresp_val = (resp_at >= 0 && c >= resp_at);
            if (o_memreq_val && mst < mstall) begin
                i_memreq_rdy = 1'b0;
                mst++;
            end else begin
                i_memreq_rdy = 1'b1;
            end
            if (o_cacheresp_val && rst_cnt < rstall) begin
                i_cacheresp_rdy = 1'b0;
                rst_cnt++;
            end else begin
                i_cacheresp_rdy = 1'b1;
            end
            if (abort_rw && o_memresp_rdy && seq[7:0] == 8'h90) begin
                i_reset = 1'b1;
                #1;
                chk_eq("reset_outs_zero", ctl_outs(), 32'd0);
                @(posedge clk);
                model_reset();
                aborted = 1'b1;
                @(negedge clk);
                i_reset = 1'b0;
                #1;
                chk_eq("idle_after_reset", 32'(o_cachereq_rdy), 32'd1);
            end else begin
                #1;
                if (o_cachereq_rdy) rdy_bad = 1'b1;
                cur_twen = o_tag_array_wen;
                twen |= o_tag_array_wen;
                dwen |= o_data_array_wen;
                if (o_memreq_val && i_memreq_rdy) begin
                    seq = (seq << 8) | 32'({3'b100, o_memreq_addr_mux_sel, 1'b0, o_memreq_type});
                    resp_at = c + 2;
                    mst = 0;
                end
                if (i_memresp_val && o_memresp_rdy) resp_at = -1;
                if (o_cacheresp_val) begin
                    if (!seen_resp) begin
                        seen_resp = 1'b1;
                        hold_hit  = o_cacheresp_hit;
                        chk_eq("resp_latency", 32'(c), 32'(exp_lat));
                        chk_eq("resp_hit", 32'(o_cacheresp_hit), 32'((typ != 3'd2) && hit));
                        chk_eq("resp_type", 32'(o_cacheresp_type), 32'(typ));
                    end else begin
                        chk_eq("resp_hold", 32'(o_cacheresp_hit), 32'(hold_hit));
                    end
                    if (i_cacheresp_rdy) done = 1'b1;
                end
                @(posedge clk);
                for (int w = 0; w < NW; w++) if (cur_twen[w]) dp_tag[idx][w] = tg;
            end
        end

        if (!aborted) begin
            chk_eq("txn_done", 32'(done), 32'd1);
            chk_eq("memreq_seq", seq, exp_seq);
            chk_eq("tag_wen_way", 32'(twen), exp_twen);
            chk_eq("data_wen_way", 32'(dwen), exp_dwen);
            chk_eq("req_rdy_busy", 32'(rdy_bad), 32'd0);
            m_valid[idx][way] = 1'b1;
            m_tag[idx][way]   = tg;
            if (typ == 3'd1) m_dirty[idx][way] = 1'b1;
            else if (typ == 3'd2 || !hit) m_dirty[idx][way] = 1'b0;
            m_lru[idx] = (way == 0);
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_cachereq_val = 1'b0; i_cacheresp_rdy = 1'b0; i_memreq_rdy = 1'b0;
        i_memresp_val = 1'b0; i_cachereq_type = 3'd0; i_cachereq_idx = '0; i_tag_match = '0;
        model_reset();
        for (int s = 0; s < NS; s++) for (int w = 0; w < NW; w++) dp_tag[s][w] = 0;

        repeat (2) @(negedge clk);
        #1;
        chk_eq("reset_outs", ctl_outs(), 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        chk_eq("idle_rdy", 32'(o_cachereq_rdy), 32'd1);
        chk_eq("idle_no_resp", 32'(o_cacheresp_val), 32'd0);

        // Cold miss then hit; INIT then hit
        run_req(3'd0, 3, 1, 0, 0, 1'b0);
        run_req(3'd0, 3, 1, 0, 0, 1'b0);
        run_req(3'd2, 5, 2, 0, 0, 1'b0);
        run_req(3'd0, 5, 2, 0, 0, 1'b0);
        // LRU: A, B, C in set 0, then B hits and A misses
        run_req(3'd0, 0, 1, 0, 0, 1'b0);
        run_req(3'd0, 0, 2, 0, 0, 1'b0);
        run_req(3'd0, 0, 3, 0, 0, 1'b0);
        run_req(3'd0, 0, 2, 0, 0, 1'b0);
        run_req(3'd0, 0, 1, 0, 0, 1'b0);
        // Dirty eviction in set 2, then again with memory and response back-pressure
        run_req(3'd0, 2, 1, 0, 0, 1'b0);
        run_req(3'd0, 2, 2, 0, 0, 1'b0);
        run_req(3'd1, 2, 1, 0, 0, 1'b0);
        run_req(3'd0, 2, 2, 0, 0, 1'b0);
        run_req(3'd0, 2, 3, 0, 0, 1'b0);
        run_req(3'd1, 2, 2, 0, 0, 1'b0);
        run_req(3'd0, 2, 3, 0, 0, 1'b0);
        run_req(3'd1, 2, 4, 3, 4, 1'b0);
        // Reset during refill wait drops everything
        run_req(3'd0, 7, 9, 0, 0, 1'b1);
        run_req(3'd0, 3, 1, 0, 0, 1'b0);
        run_req(3'd0, 7, 9, 0, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            run_req(($urandom_range(9, 0) == 0) ? 3'd2 : 3'($urandom_range(1, 0)),
                    int'($urandom_range(3, 0)) + 8, int'($urandom_range(4, 1)),
                    int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
